// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder with a one-word holding register.
// Feeds a serial bit stream with first/last-bit markers to a downstream detector.
module serial_word_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    input  logic             en,
    output logic             out,
    output logic             out_valid,
    output logic             word_start,
    output logic             word_last,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             hold_full;

    logic accept;
    logic word_end;

    assign accept   = load && ready;
    assign word_end = (state == StShift) && en && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            sreg      <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        sreg  <= data_in;
                        cnt   <= '0;
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (word_end) begin
                        // Held word has priority; ready is low then, so no new accept competes.
                        if (hold_full) begin
                            sreg      <= hold;
                            hold_full <= 1'b0;
                            cnt       <= '0;
                        end else if (accept) begin
                            sreg <= data_in;
                            cnt  <= '0;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        if (en) begin
                            sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                              : {1'b0, sreg[WIDTH-1:1]};
                            cnt  <= cnt + 1'b1;
                        end
                        if (accept) begin
                            hold      <= data_in;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign ready      = ~hold_full;
    assign out_valid  = (state == StShift);
    assign out        = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign word_start = out_valid && (cnt == '0);
    assign word_last  = out_valid && (cnt == CNT_LAST);
    assign busy       = out_valid || hold_full;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a word-queue reference model.
module tb_serial_word_feeder;

    localparam int unsigned W = 8;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       load;
    logic       en;

    logic ready_m, out_m, out_valid_m, word_start_m, word_last_m, busy_m;
    logic ready_l, out_l, out_valid_l, word_start_l, word_last_l, busy_l;

    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load       (load),
        .ready      (ready_m),
        .en         (en),
        .out        (out_m),
        .out_valid  (out_valid_m),
        .word_start (word_start_m),
        .word_last  (word_last_m),
        .busy       (busy_m)
    );

    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load       (load),
        .ready      (ready_l),
        .en         (en),
        .out        (out_l),
        .out_valid  (out_valid_l),
        .word_start (word_start_l),
        .word_last  (word_last_l),
        .busy       (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: words not yet fully emitted, oldest first, and bit index into the oldest.
    logic [7:0] mq[$];
    int         midx = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic       v;
        logic [7:0] w;
        v = (mq.size() > 0);
        w = v ? mq[0] : 8'h00;
        check_val("msb.out_valid", 32'(out_valid_m), 32'(v));
        check_val("lsb.out_valid", 32'(out_valid_l), 32'(v));
        check_val("msb.ready", 32'(ready_m), 32'(mq.size() < 2));
        check_val("lsb.ready", 32'(ready_l), 32'(mq.size() < 2));
        check_val("msb.busy", 32'(busy_m), 32'(v));
        check_val("lsb.busy", 32'(busy_l), 32'(v));
        check_val("msb.word_start", 32'(word_start_m), 32'(v && midx == 0));
        check_val("lsb.word_start", 32'(word_start_l), 32'(v && midx == 0));
        check_val("msb.word_last", 32'(word_last_m), 32'(v && midx == W - 1));
        check_val("lsb.word_last", 32'(word_last_l), 32'(v && midx == W - 1));
        if (v) begin
            check_val("msb.out", 32'(out_m), 32'(w[W-1-midx]));
            check_val("lsb.out", 32'(out_l), 32'(w[midx]));
        end
    endtask

    // One clock: drive inputs, advance the model over the edge, check at the falling edge.
    task automatic step(input logic r, input logic l, input logic [7:0] d, input logic e);
        logic acc, con;
        rst = r; load = l; data_in = d; en = e;
        @(posedge clk);
        acc = l && (mq.size() < 2);
        con = e && (mq.size() > 0);
        if (r) begin
            mq.delete();
            midx = 0;
        end else begin
            if (acc) mq.push_back(d);
            if (con) begin
                midx++;
                if (midx == W) begin
                    void'(mq.pop_front());
                    midx = 0;
                end
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    logic [7:0]  col_m;
    logic [7:0]  col_l;
    logic [15:0] col16;

    initial begin
        rst = 1'b1; load = 1'b1; data_in = 8'hFF; en = 1'b1;
        @(negedge clk);

        // Reset held with load asserted: nothing gets in.
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        check_val("rst.out_msb", 32'(out_m), 32'h0);
        check_val("rst.out_lsb", 32'(out_l), 32'h0);
        check_val("rst.ready", 32'(ready_m), 32'h1);
        idle(3);
        check_val("rst.no_word", 32'(out_valid_m), 32'h0);

        // Single word 0xB4.
        step(1'b0, 1'b1, 8'hB4, 1'b1);
        col_m = '0; col_l = '0;
        for (int i = 0; i < 8; i++) begin
            col_m = {col_m[6:0], out_m};
            col_l = {col_l[6:0], out_l};
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check_val("single.msb_bits", 32'(col_m), 32'hB4);
        check_val("single.lsb_bits", 32'(col_l), 32'h2D);
        check_val("single.done_busy", 32'(busy_m), 32'h0);
        idle(2);

        // Back-to-back 0x0D then 0xF0.
        step(1'b0, 1'b1, 8'h0D, 1'b1);
        col16 = '0;
        col16 = {col16[14:0], out_m};
        step(1'b0, 1'b1, 8'hF0, 1'b1);
        check_val("b2b.ready_low", 32'(ready_m), 32'h0);
        for (int i = 1; i < 16; i++) begin
            col16 = {col16[14:0], out_m};
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check_val("b2b.bits", 32'(col16), 32'h0DF0);
        idle(2);

        // Stall at bit index 3.
        step(1'b0, 1'b1, 8'hB4, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            check_val("stall.out_held", 32'(out_m), 32'h1);
        end
        idle(6);

        // Reset mid-word with a held word.
        step(1'b0, 1'b1, 8'hB4, 1'b1);
        step(1'b0, 1'b1, 8'h55, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'hAA, 1'b1);
        check_val("midrst.busy", 32'(busy_m), 32'h0);
        step(1'b0, 1'b1, 8'h81, 1'b1);
        col_m = '0;
        for (int i = 0; i < 8; i++) begin
            col_m = {col_m[6:0], out_m};
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check_val("midrst.fresh_bits", 32'(col_m), 32'h81);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_feeder.md
# serial_word_feeder

Parallel-to-serial stage that sits directly upstream of the serial sequence detector. It accepts WIDTH-bit words through a valid/ready handshake and shifts them out one bit per consumed clock cycle. A one-word holding register lets back-to-back words stream with no idle bit between them. Its `out`/`out_valid` pair drives the detector's serial `in`. For a continuous bit stream, tie `en` high.

## Interface

- `WIDTH`, default 8: word width in bits, minimum 2.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- `clk`  in  1  : single clock, rising edge.
- `rst`  in  1  : synchronous active-high reset.
- `data_in`  in  WIDTH  : word to serialize.
- `load`  in  1  : word valid.
- `ready`  out  1  : block can accept a word; acceptance = `load && ready` at a rising edge.
- `en`  in  1  : consume enable; the current bit is consumed at a rising edge where `out_valid && en`.
- `out`  out  1  : current serial bit, driven from a register bit with no combinational path from inputs.
- `out_valid`  out  1  : `out` carries a valid bit.
- `word_start`  out  1  : `out_valid` and `out` is the first bit of a word.
- `word_last`  out  1  : `out_valid` and `out` is the last bit of a word.
- `busy`  out  1  : shifter or holding register occupied.

## Operation

- Storage:
  - shift register `sreg` (WIDTH bits);
  - bit counter `cnt` (0..WIDTH-1, width clog2(WIDTH));
  - holding register `hold` with flag `hold_full`.
- FSM with two states: IDLE and SHIFT. `out_valid` = (state == SHIFT).
- `ready` = ~`hold_full`. It is registered and does not depend on `load` or `en`.
- IDLE:
  - On accept, `data_in` goes straight into `sreg`, `cnt` = 0, next state SHIFT.
  - `hold` stays empty.
- SHIFT, consume without word end (`en`=1, `cnt` < WIDTH-1):
  - `sreg` shifts toward the output end: left if MSB_FIRST, else right. Fill bit is 0.
  - `cnt` increments.
- SHIFT, consume with word end (`en`=1, `cnt` == WIDTH-1), in priority order:
  - `hold_full`: `sreg` ← `hold`, `hold_full` ← 0, `cnt` ← 0, stay in SHIFT.
  - else accept this cycle: `sreg` ← `data_in`, `cnt` ← 0, stay in SHIFT.
  - else: go to IDLE.
- SHIFT, no end-of-word reload: an accept writes `data_in` into `hold` and sets `hold_full`.
- `hold_full` is set at most once, because `ready` is low while it is set.
- `en`=0 stalls the shift:
  - `sreg`, `cnt`, `out` and `out_valid` hold their values;
  - loads are still accepted into `hold` if it is empty.
- Output decode:
  - `out` = `sreg[WIDTH-1]` if MSB_FIRST, else `sreg[0]`.
  - `word_start` = `out_valid && cnt==0`.
  - `word_last` = `out_valid && cnt==WIDTH-1`.
  - `busy` = `out_valid || hold_full`.
- Reset (synchronous, any state, including mid-word):
  - state IDLE, `sreg`=0, `cnt`=0, `hold`=0, `hold_full`=0;
  - in-flight and held words are discarded;
  - `load` is ignored while `rst` is high.

## Timing

- Reset values, valid the cycle after the reset edge: `out`=0, `out_valid`=0, `word_start`=0, `word_last`=0, `busy`=0, `ready`=1.
- Latency:
  - A word accepted at edge N in IDLE presents its first bit in cycle N+1.
  - With `en`=1 continuously, its last bit is in cycle N+WIDTH.
- Throughput:
  - one bit per cycle while `en`=1;
  - zero idle cycles between consecutive words if the next word is in `hold`, or is accepted in the last-bit cycle.
- A word accepted during the last-bit cycle of the previous word is loaded directly into `sreg`, so no gap.
- `ready` falls the cycle after the accept that fills `hold`.
- `ready` rises the cycle after `hold` transfers into `sreg`.
- At most one word is accepted per edge. The block holds no more than 2 words (`sreg` + `hold`).

## Test plan

- Reset: hold `rst`=1 for 2 cycles with `load`=1 and `data_in`=0xFF -> `out_valid`=0, `out`=0, `ready`=1, `busy`=0; no word emitted after `rst` falls.
- Single word: WIDTH=8, MSB_FIRST=1, `en`=1, accept 0xB4 at edge N:
  - `out` = 1,0,1,1,0,1,0,0 in cycles N+1..N+8;
  - `word_start` only in N+1, `word_last` only in N+8;
  - `out_valid`=0 and `busy`=0 in N+9.
- Back-to-back: accept 0x0D, then 0xF0 one cycle later -> 16 contiguous valid bits 00001101 11110000; `ready`=0 from cycle after second accept until transfer; `word_start` at bit 1 and bit 9.
- Stall: send 0xB4, drop `en` for 3 cycles while `cnt`=3 -> `out`=1 held for those 3 cycles, `cnt` frozen; remaining bits 0,1,0,0 follow once `en`=1; total 8 consumed bits.
- Reset mid-word: after 4 bits of 0xB4 with 0x55 held, assert `rst` 1 cycle -> next cycle `out_valid`=0, `ready`=1, `busy`=0; a fresh 0x81 then emits 1,0,0,0,0,0,0,1 from bit 0.
- LSB-first: MSB_FIRST=0, word 0xB4 -> `out` = 0,0,1,0,1,1,0,1; `word_last` on the final 1.
